// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM controller: FSM states,
// opcode byte values and image indices.
package boot_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_DEC = 8'h76;
  localparam logic [7:0] OP_JMP = 8'h80;
  localparam logic [7:0] OP_JNZ = 8'hB0;
  localparam logic [7:0] OP_OUT = 8'hD0;
  localparam logic [7:0] OP_LDI = 8'hE0;

  localparam logic [1:0] IMG_SLOW = 2'd0;
  localparam logic [1:0] IMG_FAST = 2'd1;
  localparam logic [1:0] IMG_NOP2 = 2'd2;
  localparam logic [1:0] IMG_NOP3 = 2'd3;

  // Image select width; a single image still gets a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boot_rom_image.sv
// Combinational boot image table: (image, byte index) -> program byte.
// Unlisted bytes and images 2..3 read as NOP.
module boot_rom_image
  import boot_rom_pkg::*;
(
  input  logic [1:0] img,
  input  logic [7:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = OP_NOP;
    case (img)
      IMG_SLOW: begin
        case (idx)
          8'h00: data = OP_LDI;
          8'h01: data = 8'h01;
          8'h02: data = 8'h00;
          8'h03: data = OP_OUT;
          8'h04: data = 8'h01;
          8'h05: data = OP_LDI;
          8'h06: data = 8'hFF;
          8'h07: data = 8'h00;
          8'h08: data = OP_DEC;
          8'h09: data = OP_JNZ;
          8'h0A: data = 8'h08;
          8'h0B: data = 8'h00;
          8'h0C: data = OP_LDI;
          8'h0D: data = 8'h00;
          8'h0E: data = 8'h00;
          8'h0F: data = OP_OUT;
          8'h10: data = 8'h01;
          8'h11: data = OP_LDI;
          8'h12: data = 8'hFF;
          8'h13: data = 8'h00;
          8'h14: data = OP_DEC;
          8'h15: data = OP_JNZ;
          8'h16: data = 8'h14;
          8'h17: data = 8'h00;
          8'h18: data = OP_JMP;
          8'h19: data = 8'h00;
          8'h1A: data = 8'h00;
          default: data = OP_NOP;
        endcase
      end
      IMG_FAST: begin
        case (idx)
          8'h00: data = OP_LDI;
          8'h01: data = 8'h01;
          8'h02: data = 8'h00;
          8'h03: data = OP_OUT;
          8'h04: data = 8'h01;
          8'h05: data = OP_LDI;
          8'h06: data = 8'h00;
          8'h07: data = 8'h00;
          8'h08: data = OP_OUT;
          8'h09: data = 8'h01;
          8'h0A: data = OP_JMP;
          8'h0B: data = 8'h00;
          8'h0C: data = 8'h00;
          default: data = OP_NOP;
        endcase
      end
      IMG_NOP2, IMG_NOP3: data = OP_NOP;
      default: data = OP_NOP;
    endcase
  end

endmodule

// File: rtl/boot_rom_ctrl.sv
// Boot ROM fetch controller with wait-state emulation of SPI memory timing.
// Define BOOT_ROM_CKSUM_EN to build the running checksum of delivered bytes.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for req; addr/img_sel captured on accept
// ST_WAIT | wait-state down-counter running; req drop aborts
// ST_RESP | ready pulse, rdata holds the fetched byte
module boot_rom_ctrl
  import boot_rom_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int NUM_IMAGES  = 2,
  parameter int WAIT_STATES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [sel_width(NUM_IMAGES)-1:0]  img_sel,
  input  logic                              req,
  input  logic [ADDR_W-1:0]                 addr,
  output logic                              ready,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              oor,
  output logic [7:0]                        cksum
);

  localparam int IMG_W = sel_width(NUM_IMAGES);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              load;
  logic [ADDR_W-1:0] addr_q, src_addr;
  logic [IMG_W-1:0]  img_q, src_img;
  logic [DATA_W-1:0] rdata_q;
  logic              oor_q;
  logic              in_range;
  logic [7:0]        rom_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      img_q   <= '0;
      rdata_q <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q <= addr;
        img_q  <= img_sel;
      end
      if (state_d == ST_RESP) begin
        rdata_q <= in_range ? DATA_W'(rom_byte) : '0;
        if (!in_range) oor_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          load    = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An abort wins even on the terminal count.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the lookup happens on the accept edge itself,
  // before the latches have captured the request.
  assign src_addr = (state_q == ST_IDLE) ? addr : addr_q;
  assign src_img  = (state_q == ST_IDLE) ? img_sel : img_q;
  assign in_range = (32'(src_addr) < 32'(DEPTH)) && (32'(src_img) < 32'(NUM_IMAGES));

  boot_rom_image u_image (
    .img  (2'(src_img)),
    .idx  (8'(src_addr[IDX_W-1:0])),
    .data (rom_byte)
  );

  assign ready = (state_q == ST_RESP);
  assign rdata = rdata_q;
  assign oor   = oor_q;

`ifdef BOOT_ROM_CKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum_q <= '0;
    end else if (state_q == ST_RESP) begin
      cksum_q <= cksum_q + 8'(rdata_q);
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = 8'h00;
`endif

endmodule
